// File: rtl/multi_rate_pulse_gen_if.sv
// rtl/multi_rate_pulse_gen_if.sv - control and strobe bundle for multi_rate_pulse_gen
interface multi_rate_pulse_gen_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       oneshot;
  logic [CHANNELS-1:0]       div_load;
  logic [CHANNELS*CNT_W-1:0] div_val;
  logic                      sync;
  logic [CHANNELS-1:0]       pulse;
  logic [CHANNELS-1:0]       armed;

  modport master (
    output en, oneshot, div_load, div_val, sync,
    input  pulse, armed
  );

  modport slave (
    input  en, oneshot, div_load, div_val, sync,
    output pulse, armed
  );
endinterface

// File: rtl/multi_rate_pulse_gen.sv
// rtl/multi_rate_pulse_gen.sv - CHANNELS independent divisor-driven single-cycle rate pulses
module multi_rate_pulse_gen #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input logic                   clk,
  input logic                   rst,
  multi_rate_pulse_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]    div_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    term  [CHANNELS];
  logic [CHANNELS-1:0] arm_q;
  logic [CHANNELS-1:0] pulse_q;

  // Terminal count is E-1 with E = max(DIV, 1), so 0 and 1 both pulse every enabled cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      term[i] = (div_q[i] == '0) ? '0 : div_q[i] - ONE;
    end
  end

  // Per-channel update, priority rst > sync > div_load > count; loads always clear CNT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        div_q[i]   <= DEF_DIV;
        cnt_q[i]   <= '0;
        arm_q[i]   <= 1'b1;
        pulse_q[i] <= 1'b0;
      end else if (bus.sync) begin
        cnt_q[i]   <= '0;
        arm_q[i]   <= 1'b1;
        pulse_q[i] <= 1'b0;
        if (bus.div_load[i]) begin
          div_q[i] <= bus.div_val[i*CNT_W +: CNT_W];
        end
      end else if (bus.div_load[i]) begin
        div_q[i]   <= bus.div_val[i*CNT_W +: CNT_W];
        cnt_q[i]   <= '0;
        arm_q[i]   <= 1'b1;
        pulse_q[i] <= 1'b0;
      end else if (bus.en[i] && arm_q[i]) begin
        if (cnt_q[i] == term[i]) begin
          cnt_q[i]   <= '0;
          pulse_q[i] <= 1'b1;
          if (bus.oneshot[i]) begin
            arm_q[i] <= 1'b0;
          end
        end else begin
          cnt_q[i]   <= cnt_q[i] + ONE;
          pulse_q[i] <= 1'b0;
        end
      end else begin
        pulse_q[i] <= 1'b0;
      end
    end
  end

  assign bus.pulse = pulse_q;
  assign bus.armed = arm_q;
endmodule

// File: tb/tb_multi_rate_pulse_gen.sv
// tb/tb_multi_rate_pulse_gen.sv - scoreboard bench for multi_rate_pulse_gen
module tb_multi_rate_pulse_gen;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_on = 1'b0;
  int   exp_q[$];

  multi_rate_pulse_gen_if #(.CHANNELS(4), .CNT_W(16)) bus ();

  multi_rate_pulse_gen #(.CHANNELS(4), .CNT_W(16), .DEFAULT_DIV(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected pulses are keyed cycle*16+channel and kept sorted.
  function automatic void expect_pulse(input int c, input int ch);
    int key;
    int idx;
    key = c * 16 + ch;
    idx = 0;
    while (idx < exp_q.size() && exp_q[idx] <= key) idx++;
    exp_q.insert(idx, key);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int ch, input int val, output int l);
    bus.div_val[ch*16 +: 16] = 16'(val);
    bus.div_load[ch] = 1'b1;
    l = cyc + 1;
    tick(1);
    bus.div_load[ch] = 1'b0;
  endtask

  // Monitor: every observed pulse bit must match the head of the expectation queue.
  always @(negedge clk) begin
    int key;
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc * 16) begin
        compared++;
        mismatched++;
        $display("FAIL missed_pulse: ch%0d got no pulse, required pulse at cycle %0d", exp_q[0] % 16, exp_q[0] / 16);
        void'(exp_q.pop_front());
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (bus.pulse[ch] !== 1'b0) begin
          key = cyc * 16 + ch;
          while (exp_q.size() > 0 && exp_q[0] < key) begin
            compared++;
            mismatched++;
            $display("FAIL missed_pulse: ch%0d got no pulse, required pulse at cycle %0d", exp_q[0] % 16, exp_q[0] / 16);
            void'(exp_q.pop_front());
          end
          compared++;
          if (exp_q.size() > 0 && exp_q[0] == key) begin
            void'(exp_q.pop_front());
          end else begin
            mismatched++;
            $display("FAIL extra_pulse: ch%0d pulse=%b at cycle %0d, required 0", ch, bus.pulse[ch], cyc);
          end
        end
      end
    end
  end

  initial begin
    int r, l, l2, a, b, s;
    bus.en = '0;
    bus.oneshot = '0;
    bus.div_load = '0;
    bus.div_val = '0;
    bus.sync = 1'b0;
    rst = 1'b1;

    // Reset default: DIV = 100 on ch0.
    tick(2);
    rst = 1'b0;
    r = cyc;
    mon_on = 1'b1;
    bus.en = 4'b0001;
    check("reset_armed", 32'(bus.armed), 32'hF);
    check("reset_pulse", 32'(bus.pulse), 32'h0);
    expect_pulse(r + 100, 0);
    expect_pulse(r + 200, 0);
    expect_pulse(r + 300, 0);
    tick(302);
    bus.en = 4'b0000;
    check("default_armed", 32'(bus.armed), 32'hF);

    // Periodic DIV = 5 on ch1, then DIV = 0 (every cycle).
    bus.en[1] = 1'b1;
    load(1, 5, l);
    for (int k = 1; k <= 4; k++) expect_pulse(l + 5 * k, 1);
    tick(22);
    load(1, 0, l2);
    for (int k = 1; k <= 6; k++) expect_pulse(l2 + k, 1);
    tick(6);
    bus.en[1] = 1'b0;
    tick(3);

    // One-shot DIV = 3 on ch2, re-armed by sync.
    bus.oneshot[2] = 1'b1;
    bus.en[2] = 1'b1;
    load(2, 3, l);
    expect_pulse(l + 3, 2);
    tick(2);
    check("oneshot_armed_before", 32'(bus.armed[2]), 32'h1);
    tick(1);
    check("oneshot_armed_fall", 32'(bus.armed[2]), 32'h0);
    tick(50);
    check("oneshot_still_disarmed", 32'(bus.armed[2]), 32'h0);
    bus.sync = 1'b1;
    s = cyc + 1;
    tick(1);
    bus.sync = 1'b0;
    check("sync_rearm", 32'(bus.armed[2]), 32'h1);
    expect_pulse(s + 3, 2);
    tick(10);
    check("oneshot_after_sync", 32'(bus.armed[2]), 32'h0);
    bus.en[2] = 1'b0;
    bus.oneshot[2] = 1'b0;

    // Enable gating: ch3 DIV = 4, en low for two edges after CNT reaches 2.
    bus.en[3] = 1'b1;
    load(3, 4, l);
    expect_pulse(l + 4, 3);
    expect_pulse(l + 10, 3);
    expect_pulse(l + 14, 3);
    expect_pulse(l + 18, 3);
    tick(6);
    bus.en[3] = 1'b0;
    tick(2);
    bus.en[3] = 1'b1;
    tick(11);
    bus.en[3] = 1'b0;
    tick(3);

    // Sync alignment with a simultaneous ch1 load to 8.
    bus.en[0] = 1'b1;
    load(0, 4, a);
    tick(2);
    bus.en[1] = 1'b1;
    load(1, 6, b);
    expect_pulse(a + 4, 0);
    expect_pulse(a + 8, 0);
    expect_pulse(b + 6, 1);
    tick(6);
    bus.sync = 1'b1;
    bus.div_val[16 +: 16] = 16'd8;
    bus.div_load[1] = 1'b1;
    s = cyc + 1;
    tick(1);
    bus.sync = 1'b0;
    bus.div_load[1] = 1'b0;
    for (int k = 1; k <= 4; k++) expect_pulse(s + 4 * k, 0);
    expect_pulse(s + 8, 1);
    expect_pulse(s + 16, 1);
    tick(17);
    bus.en = 4'b0000;
    tick(3);

    // Reset mid-count: ch1 DIV = 10 with CNT at 7.
    bus.en = 4'b0010;
    load(1, 10, l);
    tick(7);
    rst = 1'b1;
    r = cyc + 1;
    tick(1);
    rst = 1'b0;
    check("midreset_armed", 32'(bus.armed), 32'hF);
    check("midreset_pulse", 32'(bus.pulse), 32'h0);
    expect_pulse(r + 100, 1);
    tick(102);
    bus.en = 4'b0000;
    tick(2);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
